// File: rtl/execute_stage_p_if.sv
// Decode-to-execute and execute-to-MEM handshake bundle for execute_stage_p.
// The master drives the op and the downstream ready. The slave (the execute
// stage) returns in_ready and the registered result.
interface execute_stage_p_if #(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic               in_regwrite;
   logic               in_memtoreg;
   logic               in_bustoreg;
   logic               in_memread;
   logic               in_memwrite;
   logic [4:0]         in_aluop;
   logic               in_alusrc;
   logic [DATA_W-1:0]  in_reg1;
   logic [DATA_W-1:0]  in_reg2;
   logic [DATA_W-1:0]  in_imm;
   logic [RADDR_W-1:0] in_rs1;
   logic [RADDR_W-1:0] in_rs2;
   logic [RADDR_W-1:0] in_rd;

   logic               out_valid;
   logic               out_ready;
   logic               out_regwrite;
   logic               out_memtoreg;
   logic               out_bustoreg;
   logic               out_memread;
   logic               out_memwrite;
   logic [DATA_W-1:0]  out_alu;
   logic [DATA_W-1:0]  out_src2;
   logic [RADDR_W-1:0] out_rd;

   modport master (
      output in_valid, in_regwrite, in_memtoreg, in_bustoreg, in_memread,
             in_memwrite, in_aluop, in_alusrc, in_reg1, in_reg2, in_imm,
             in_rs1, in_rs2, in_rd, out_ready,
      input  in_ready, out_valid, out_regwrite, out_memtoreg, out_bustoreg,
             out_memread, out_memwrite, out_alu, out_src2, out_rd
   );

   modport slave (
      input  in_valid, in_regwrite, in_memtoreg, in_bustoreg, in_memread,
             in_memwrite, in_aluop, in_alusrc, in_reg1, in_reg2, in_imm,
             in_rs1, in_rs2, in_rd, out_ready,
      output in_ready, out_valid, out_regwrite, out_memtoreg, out_bustoreg,
             out_memread, out_memwrite, out_alu, out_src2, out_rd
   );
endinterface

// File: rtl/execute_stage_p.sv
// Handshaked CPU execute stage: operand forwarding from MEM, a single-cycle
// ALU and an iterative multiply that occupies the stage for MUL_CYCLES cycles.
// Optional feature macro EX_BYPASS_WB_EN adds the wb_* ports and lower-priority
// forwarding from the WB stage.
module execute_stage_p #(
   parameter int DATA_W     = 16,
   parameter int RADDR_W    = 4,
   parameter int MUL_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   execute_stage_p_if.slave   bus,
   input  logic               mem_regwrite,
   input  logic               mem_memread,
   input  logic [RADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0]  mem_data,
`ifdef EX_BYPASS_WB_EN
   input  logic               wb_regwrite,
   input  logic [RADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0]  wb_data,
`endif
   output logic [2:0]         flag_out,
   output logic               busy
);

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_AND   = 5'd2;
   localparam logic [4:0] OP_OR    = 5'd3;
   localparam logic [4:0] OP_XOR   = 5'd4;
   localparam logic [4:0] OP_SLL   = 5'd5;
   localparam logic [4:0] OP_SRL   = 5'd6;
   localparam logic [4:0] OP_SRA   = 5'd7;
   localparam logic [4:0] OP_MUL   = 5'd9;

   localparam int MSB   = DATA_W - 1;
   localparam int SH_W  = $clog2(DATA_W);
   localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

   // The multiplier consumes CHUNK bits per MUL-state cycle so that all
   // DATA_W bits are retired before the stage reaches DONE.
   localparam int MUL_STEPS = MUL_CYCLES - 1;
   localparam int CHUNK     = (DATA_W + MUL_STEPS - 1) / MUL_STEPS;
   localparam logic [DATA_W-1:0] CHUNK_MASK = {DATA_W{1'b1}} >> (DATA_W - CHUNK);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               outValid_q;
   logic [4:0]         outCtl_q;
   logic [DATA_W-1:0]  outAlu_q;
   logic [DATA_W-1:0]  outSrc2_q;
   logic [RADDR_W-1:0] outRd_q;
   logic [2:0]         flag_q;

   logic [DATA_W-1:0]  mulAcc_q;
   logic [DATA_W-1:0]  mulCand_q;
   logic [DATA_W-1:0]  mulPlier_q;
   logic [4:0]         mulCtl_q;
   logic [DATA_W-1:0]  mulSrc2_q;
   logic [RADDR_W-1:0] mulRd_q;

   logic               memHit1;
   logic               memHit2;
   logic               loadUse;
   logic [DATA_W-1:0]  fwdA;
   logic [DATA_W-1:0]  fwdB;
   logic [DATA_W-1:0]  opB;
   logic [DATA_W-1:0]  sum;
   logic [DATA_W-1:0]  diff;
   logic [DATA_W-1:0]  bInv;
   logic [SH_W-1:0]    shamt;
   logic [DATA_W-1:0]  aluRes;
   logic [2:0]         aluFlags;
   logic [DATA_W-1:0]  mulPartial;
   logic [4:0]         inCtl;
   logic               isMul;
   logic               accept;

   assign inCtl  = {bus.in_regwrite, bus.in_memtoreg, bus.in_bustoreg,
                    bus.in_memread, bus.in_memwrite};
   assign isMul  = (bus.in_aluop == OP_MUL);
   assign accept = bus.in_valid && bus.in_ready;

   // Resolve both source operands; MEM wins over WB, and r0 never forwards.
   // A load still sitting in MEM cannot be forwarded, so it stalls decode.
   always_comb begin
      memHit1 = mem_regwrite && (mem_rd == bus.in_rs1) && (bus.in_rs1 != '0);
      memHit2 = mem_regwrite && (mem_rd == bus.in_rs2) && (bus.in_rs2 != '0);
      loadUse = mem_memread && (memHit1 || memHit2);
      fwdA    = bus.in_reg1;
      fwdB    = bus.in_reg2;
`ifdef EX_BYPASS_WB_EN
      if (wb_regwrite && (wb_rd == bus.in_rs1) && (bus.in_rs1 != '0)) begin
         fwdA = wb_data;
      end
      if (wb_regwrite && (wb_rd == bus.in_rs2) && (bus.in_rs2 != '0)) begin
         fwdB = wb_data;
      end
`endif
      if (memHit1) begin
         fwdA = mem_data;
      end
      if (memHit2) begin
         fwdB = mem_data;
      end
      opB = bus.in_alusrc ? bus.in_imm : fwdB;
   end

   // Single-cycle ALU; each op decides which flags it refreshes, the rest keep
   // their previous value.
   always_comb begin
      sum      = fwdA + opB;
      diff     = fwdA - opB;
      bInv     = ~opB;
      shamt    = opB[SH_W-1:0];
      aluRes   = opB;
      aluFlags = flag_q;
      case (bus.in_aluop)
         OP_ADD: begin
            aluRes   = sum;
            aluFlags = {sum[MSB], (fwdA[MSB] == opB[MSB]) && (sum[MSB] != fwdA[MSB]),
                        sum == '0};
         end
         OP_SUB: begin
            aluRes   = diff;
            aluFlags = {diff[MSB], (fwdA[MSB] == bInv[MSB]) && (diff[MSB] != fwdA[MSB]),
                        diff == '0};
         end
         OP_AND: begin
            aluRes      = fwdA & opB;
            aluFlags[0] = (aluRes == '0);
         end
         OP_OR: begin
            aluRes      = fwdA | opB;
            aluFlags[0] = (aluRes == '0);
         end
         OP_XOR: begin
            aluRes      = fwdA ^ opB;
            aluFlags[0] = (aluRes == '0);
         end
         OP_SLL: begin
            aluRes      = fwdA << shamt;
            aluFlags[0] = (aluRes == '0);
         end
         OP_SRL: begin
            aluRes      = fwdA >> shamt;
            aluFlags[0] = (aluRes == '0);
         end
         OP_SRA: begin
            aluRes      = $signed(fwdA) >>> shamt;
            aluFlags[0] = (aluRes == '0);
         end
         default: begin
            aluRes   = opB;
            aluFlags = flag_q;
         end
      endcase
   end

   // One multiplier chunk: the shifted multiplicand times the low CHUNK bits.
   always_comb begin
      mulPartial = mulCand_q * (mulPlier_q & CHUNK_MASK);
   end

   // Control FSM, multiplier iteration and the output pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         outValid_q <= 1'b0;
         outCtl_q   <= '0;
         outAlu_q   <= '0;
         outSrc2_q  <= '0;
         outRd_q    <= '0;
         flag_q     <= '0;
         mulAcc_q   <= '0;
         mulCand_q  <= '0;
         mulPlier_q <= '0;
         mulCtl_q   <= '0;
         mulSrc2_q  <= '0;
         mulRd_q    <= '0;
      end else if (flush) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         outValid_q <= 1'b0;
      end else begin
         if (outValid_q && bus.out_ready) begin
            outValid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (isMul) begin
                     mulAcc_q   <= '0;
                     mulCand_q  <= fwdA;
                     mulPlier_q <= opB;
                     mulCtl_q   <= inCtl;
                     mulSrc2_q  <= fwdB;
                     mulRd_q    <= bus.in_rd;
                     cnt_q      <= CNT_W'(MUL_CYCLES - 1);
                     state_q    <= MUL;
                  end else begin
                     outAlu_q   <= aluRes;
                     outSrc2_q  <= fwdB;
                     outRd_q    <= bus.in_rd;
                     outCtl_q   <= inCtl;
                     flag_q     <= aluFlags;
                     outValid_q <= 1'b1;
                  end
               end
            end
            MUL: begin
               mulAcc_q   <= mulAcc_q + mulPartial;
               mulCand_q  <= mulCand_q << CHUNK;
               mulPlier_q <= mulPlier_q >> CHUNK;
               cnt_q      <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (!outValid_q || bus.out_ready) begin
                  outAlu_q   <= mulAcc_q;
                  outSrc2_q  <= mulSrc2_q;
                  outRd_q    <= mulRd_q;
                  outCtl_q   <= mulCtl_q;
                  flag_q     <= {flag_q[2:1], mulAcc_q == '0};
                  outValid_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready = rst_n && (state_q == IDLE) && (!outValid_q || bus.out_ready)
                         && !loadUse && !flush;

   assign bus.out_valid    = outValid_q;
   assign bus.out_regwrite = outCtl_q[4];
   assign bus.out_memtoreg = outCtl_q[3];
   assign bus.out_bustoreg = outCtl_q[2];
   assign bus.out_memread  = outCtl_q[1];
   assign bus.out_memwrite = outCtl_q[0];
   assign bus.out_alu      = outAlu_q;
   assign bus.out_src2     = outSrc2_q;
   assign bus.out_rd       = outRd_q;
   assign flag_out         = flag_q;
   assign busy             = (state_q != IDLE);

endmodule
